riscv_ctrl_pipe_hazard: RTL and testbench
=========================================

Name: riscv_ctrl_pipe_hazard

Overview:
- Consumes the decode-stage control bundle and carries it through the E, M and W pipeline registers.
- Generates the hazard controls for the 5-stage core: load-use stall, branch flush and forwarding selects.
- Sits between the main/ALU decoders in the D stage and the datapath stage registers.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt (saturating)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
branch_d  in  1  decoded branch
result_src_d  in  2  decoded result select (00 ALU, 01 memory, 10 PC+4)
mem_write_d  in  1  decoded store enable
alu_src_d  in  1  decoded ALU B-operand select
reg_write_d  in  1  decoded register-file write
alu_op_d  in  2  decoded ALU op class
rs1_d, rs2_d, rd_d  in  5 each  D-stage register addresses
pc_src_e  in  1  branch taken, resolved in E
branch_e, mem_write_e, alu_src_e, reg_write_e  out  1 each  E-stage controls
result_src_e, alu_op_e  out  2 each  E-stage controls
rs1_e, rs2_e, rd_e  out  5 each  E-stage addresses
reg_write_m, mem_write_m  out  1 each  M-stage controls
result_src_m  out  2  M-stage control
rd_m  out  5  M-stage destination
reg_write_w  out  1  W-stage control
result_src_w  out  2  W-stage control
rd_w  out  5  W-stage destination
stall_f, stall_d  out  1 each  hold PC / hold IF/ID register
flush_d, flush_e  out  1 each  clear IF/ID / ID/EX register
forward_a_e, forward_b_e  out  2 each  00 register file, 01 W result, 10 M ALU result
stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (rst_n low, asynchronous): all E/M/W registers 0 (bubble), counters 0. Combinational outputs then evaluate to 0.
- E register, each rising edge:
  - flush_e=1: all E fields load 0.
  - Otherwise E captures the D-stage inputs.
  - E is never stalled.
- M register captures reg_write, mem_write, result_src, rd from E every cycle.
- W register captures reg_write, result_src, rd from M every cycle.
- Latency: D-stage input appears on the E outputs 1 cycle later, on M 2 cycles later, on W 3 cycles later.
- Load detect: load_e = reg_write_e & (result_src_e==01). Stores have result_src 01 with reg_write 0, so they must not match.
- lw_stall = load_e & (rd_e!=0) & ((rd_e==rs1_d) | (rd_e==rs2_d)).
- stall_f = stall_d = lw_stall & ~pc_src_e. A taken branch flushes the dependent instruction, so no stall is needed.
- flush_d = pc_src_e.
- flush_e = lw_stall | pc_src_e.
- forward_a_e:
  - 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e;
  - else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e;
  - else 00.
  - M has priority over W.
- forward_b_e: identical rule using rs2_e.
- x0 is never forwarded and never triggers a stall.
- stall_cnt increments on cycles with stall_d=1.
- flush_cnt increments on cycles with pc_src_e=1.
- Both counters saturate at all-ones; they hold, never wrap.
- Outputs other than the register stages are combinational from the current register state and D-stage inputs.
- Reset asserted mid-operation clears all in-flight controls immediately. No memory write may be issued from M after reset asserts.

Test Plan:
- Reset: drive rst_n=0 mid-stream with reg_write_d=1, then release.
  - Required: all stage outputs and counters read 0 asynchronously.
  - First D instruction after release reaches E after 1 edge.
- Pipeline propagation: issue an R-type bundle (reg_write=1, alu_op=10, rd_d=5).
  - Required: rd_e=5 after 1 cycle, rd_m=5 after 2, rd_w=5 after 3.
  - reg_write_w=1 in the third cycle.
- Load-use: LW with rd=7 in E (reg_write_e=1, result_src_e=01), D has rs2_d=7.
  - Required: stall_f=stall_d=flush_e=1 for one cycle; E holds a bubble next cycle.
  - Next cycle: forward_b_e=01 once LW reaches W.
- Store not a load: SW in E (result_src_e=01, reg_write_e=0, rd_e=7), rs1_d=7.
  - Required: no stall, flush_e=0.
- Forwarding priority: rd_m=rd_w=3, both reg_write=1, rs1_e=3 -> forward_a_e=10.
  - rd_m=0 with rs1_e=0 -> forward_a_e=00.
- Branch with simultaneous load-use: pc_src_e=1 and lw_stall condition true.
  - Required: flush_d=flush_e=1, stall_f=stall_d=0, flush_cnt+1, stall_cnt unchanged.
  - With CNT_W=4, 20 taken branches leave flush_cnt=15.

Source files
------------

// File: rtl/riscv_ctrl_pipe_hazard_if.sv
// Control/hazard bundle between the decode stage and the E/M/W datapath.
// The master side drives decoded controls; the slave returns staged controls.
interface riscv_ctrl_pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic             branch_d;
  logic [1:0]       result_src_d;
  logic             mem_write_d;
  logic             alu_src_d;
  logic             reg_write_d;
  logic [1:0]       alu_op_d;
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rd_d;
  logic             pc_src_e;
  logic             branch_e;
  logic             mem_write_e;
  logic             alu_src_e;
  logic             reg_write_e;
  logic [1:0]       result_src_e;
  logic [1:0]       alu_op_e;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic             reg_write_m;
  logic             mem_write_m;
  logic [1:0]       result_src_m;
  logic [4:0]       rd_m;
  logic             reg_write_w;
  logic [1:0]       result_src_w;
  logic [4:0]       rd_w;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [1:0]       forward_a_e;
  logic [1:0]       forward_b_e;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output branch_d, result_src_d, mem_write_d,
    output alu_src_d, reg_write_d, alu_op_d,
    output rs1_d, rs2_d, rd_d, pc_src_e,
    input  branch_e, mem_write_e, alu_src_e,
    input  reg_write_e, result_src_e, alu_op_e,
    input  rs1_e, rs2_e, rd_e,
    input  reg_write_m, mem_write_m,
    input  result_src_m, rd_m,
    input  reg_write_w, result_src_w, rd_w,
    input  stall_f, stall_d, flush_d, flush_e,
    input  forward_a_e, forward_b_e,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_d, result_src_d, mem_write_d,
    input  alu_src_d, reg_write_d, alu_op_d,
    input  rs1_d, rs2_d, rd_d, pc_src_e,
    output branch_e, mem_write_e, alu_src_e,
    output reg_write_e, result_src_e, alu_op_e,
    output rs1_e, rs2_e, rd_e,
    output reg_write_m, mem_write_m,
    output result_src_m, rd_m,
    output reg_write_w, result_src_w, rd_w,
    output stall_f, stall_d, flush_d, flush_e,
    output forward_a_e, forward_b_e,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/riscv_ctrl_pipe_hazard.sv
// E/M/W control pipeline plus load-use stall, branch flush and forwarding.
// Stall and flush event counters saturate at all-ones.
module riscv_ctrl_pipe_hazard #(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  riscv_ctrl_pipe_hazard_if.slave bus
);

  typedef struct packed {
    logic       branch;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } ex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic [4:0] rd;
  } wb_t;

  ex_t  ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  logic load_e;
  logic lw_stall;
  logic stall;
  logic flush_e;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // Hazard detection and forwarding selects
  always_comb begin
    load_e   = ex_q.reg_write & (ex_q.result_src == 2'b01);
    lw_stall = load_e & (ex_q.rd != 5'd0) &
               ((ex_q.rd == bus.rs1_d) | (ex_q.rd == bus.rs2_d));
    stall    = lw_stall & ~bus.pc_src_e;
    flush_e  = lw_stall | bus.pc_src_e;
    fwd_a    = 2'b00;
    fwd_b    = 2'b00;
    if (mem_q.reg_write && mem_q.rd != 5'd0 && mem_q.rd == ex_q.rs1)
      fwd_a = 2'b10;
    else if (wb_q.reg_write && wb_q.rd != 5'd0 && wb_q.rd == ex_q.rs1)
      fwd_a = 2'b01;
    if (mem_q.reg_write && mem_q.rd != 5'd0 && mem_q.rd == ex_q.rs2)
      fwd_b = 2'b10;
    else if (wb_q.reg_write && wb_q.rd != 5'd0 && wb_q.rd == ex_q.rs2)
      fwd_b = 2'b01;
  end

  // Next-state for stage registers and saturating counters
  always_comb begin
    ex_d = '0;
    if (!flush_e) begin
      ex_d.branch     = bus.branch_d;
      ex_d.mem_write  = bus.mem_write_d;
      ex_d.alu_src    = bus.alu_src_d;
      ex_d.reg_write  = bus.reg_write_d;
      ex_d.result_src = bus.result_src_d;
      ex_d.alu_op     = bus.alu_op_d;
      ex_d.rs1        = bus.rs1_d;
      ex_d.rs2        = bus.rs2_d;
      ex_d.rd         = bus.rd_d;
    end
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.result_src = ex_q.result_src;
    mem_d.rd         = ex_q.rd;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.result_src  = mem_q.result_src;
    wb_d.rd          = mem_q.rd;
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (bus.pc_src_e && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Stage registers; reset drops every in-flight control to a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.branch_e     = ex_q.branch;
  assign bus.mem_write_e  = ex_q.mem_write;
  assign bus.alu_src_e    = ex_q.alu_src;
  assign bus.reg_write_e  = ex_q.reg_write;
  assign bus.result_src_e = ex_q.result_src;
  assign bus.alu_op_e     = ex_q.alu_op;
  assign bus.rs1_e        = ex_q.rs1;
  assign bus.rs2_e        = ex_q.rs2;
  assign bus.rd_e         = ex_q.rd;
  assign bus.reg_write_m  = mem_q.reg_write;
  assign bus.mem_write_m  = mem_q.mem_write;
  assign bus.result_src_m = mem_q.result_src;
  assign bus.rd_m         = mem_q.rd;
  assign bus.reg_write_w  = wb_q.reg_write;
  assign bus.result_src_w = wb_q.result_src;
  assign bus.rd_w         = wb_q.rd;
  assign bus.stall_f      = stall;
  assign bus.stall_d      = stall;
  assign bus.flush_d      = bus.pc_src_e;
  assign bus.flush_e      = flush_e;
  assign bus.forward_a_e  = fwd_a;
  assign bus.forward_b_e  = fwd_b;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_riscv_ctrl_pipe_hazard.sv
// Directed bench for the control pipeline and hazard unit.
// Counters run at 4 bits so saturation is reachable quickly.
module tb_riscv_ctrl_pipe_hazard;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  riscv_ctrl_pipe_hazard_if #(.CNT_W(CNT_W)) bus ();

  riscv_ctrl_pipe_hazard #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_d();
    bus.branch_d     = 1'b0;
    bus.result_src_d = 2'b00;
    bus.mem_write_d  = 1'b0;
    bus.alu_src_d    = 1'b0;
    bus.reg_write_d  = 1'b0;
    bus.alu_op_d     = 2'b00;
    bus.rs1_d        = 5'd0;
    bus.rs2_d        = 5'd0;
    bus.rd_d         = 5'd0;
    bus.pc_src_e     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_d();
    #3;
    chk("rst_reg_write_e", 32'(bus.reg_write_e), 0);
    chk("rst_rd_w", 32'(bus.rd_w), 0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
    chk("rst_flush_e", 32'(bus.flush_e), 0);
    #9 rst_n = 1'b1;

    // R-type propagation E -> M -> W
    bus.reg_write_d = 1'b1;
    bus.alu_op_d    = 2'b10;
    bus.rd_d        = 5'd5;
    tick();
    chk("prop_rd_e", 32'(bus.rd_e), 5);
    chk("prop_alu_op_e", 32'(bus.alu_op_e), 2);
    chk("prop_reg_write_e", 32'(bus.reg_write_e), 1);
    clr_d();
    tick();
    chk("prop_rd_m", 32'(bus.rd_m), 5);
    chk("prop_rd_e_bubble", 32'(bus.rd_e), 0);
    tick();
    chk("prop_rd_w", 32'(bus.rd_w), 5);
    chk("prop_reg_write_w", 32'(bus.reg_write_w), 1);

    // Load-use on rs2
    bus.reg_write_d  = 1'b1;
    bus.result_src_d = 2'b01;
    bus.rd_d         = 5'd7;
    bus.rs1_d        = 5'd2;
    tick();
    bus.result_src_d = 2'b00;
    bus.rd_d         = 5'd8;
    bus.rs1_d        = 5'd4;
    bus.rs2_d        = 5'd7;
    #1;
    chk("lu_stall_f", 32'(bus.stall_f), 1);
    chk("lu_stall_d", 32'(bus.stall_d), 1);
    chk("lu_flush_e", 32'(bus.flush_e), 1);
    chk("lu_flush_d", 32'(bus.flush_d), 0);
    tick();
    chk("lu_e_bubble_rw", 32'(bus.reg_write_e), 0);
    chk("lu_e_bubble_rd", 32'(bus.rd_e), 0);
    chk("lu_rd_m", 32'(bus.rd_m), 7);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 1);
    chk("lu_stall_gone", 32'(bus.stall_d), 0);
    tick();
    chk("lu_rs2_e", 32'(bus.rs2_e), 7);
    chk("lu_rd_w", 32'(bus.rd_w), 7);
    chk("lu_fwd_b", 32'(bus.forward_b_e), 1);
    chk("lu_fwd_a", 32'(bus.forward_a_e), 0);

    // Store is not a load
    clr_d();
    bus.mem_write_d  = 1'b1;
    bus.result_src_d = 2'b01;
    bus.rd_d         = 5'd7;
    tick();
    clr_d();
    bus.rs1_d = 5'd7;
    #1;
    chk("sw_mem_write_e", 32'(bus.mem_write_e), 1);
    chk("sw_stall_d", 32'(bus.stall_d), 0);
    chk("sw_flush_e", 32'(bus.flush_e), 0);

    // Forwarding priority: M over W
    clr_d();
    bus.reg_write_d = 1'b1;
    bus.rd_d        = 5'd3;
    tick();
    tick();
    clr_d();
    bus.rs1_d = 5'd3;
    bus.rd_d  = 5'd9;
    tick();
    chk("fwd_rd_m", 32'(bus.rd_m), 3);
    chk("fwd_rd_w", 32'(bus.rd_w), 3);
    chk("fwd_a_prio", 32'(bus.forward_a_e), 2);

    // x0 is never forwarded
    clr_d();
    bus.reg_write_d = 1'b1;
    tick();
    clr_d();
    tick();
    chk("x0_reg_write_m", 32'(bus.reg_write_m), 1);
    chk("x0_fwd_a", 32'(bus.forward_a_e), 0);
    chk("x0_fwd_b", 32'(bus.forward_b_e), 0);

    // x0 load never stalls
    bus.reg_write_d  = 1'b1;
    bus.result_src_d = 2'b01;
    tick();
    clr_d();
    #1;
    chk("x0_lw_stall", 32'(bus.stall_d), 0);
    chk("x0_lw_flush_e", 32'(bus.flush_e), 0);

    // Taken branch together with load-use
    bus.reg_write_d  = 1'b1;
    bus.result_src_d = 2'b01;
    bus.rd_d         = 5'd6;
    tick();
    clr_d();
    bus.rs1_d    = 5'd6;
    bus.pc_src_e = 1'b1;
    #1;
    chk("br_flush_d", 32'(bus.flush_d), 1);
    chk("br_flush_e", 32'(bus.flush_e), 1);
    chk("br_stall_f", 32'(bus.stall_f), 0);
    chk("br_stall_d", 32'(bus.stall_d), 0);
    tick();
    chk("br_flush_cnt", 32'(bus.flush_cnt), 1);
    chk("br_stall_cnt", 32'(bus.stall_cnt), 1);
    chk("br_e_bubble", 32'(bus.reg_write_e), 0);

    // 20 taken branches in total saturate a 4-bit counter
    for (int i = 0; i < 19; i++) tick();
    chk("sat_flush_cnt", 32'(bus.flush_cnt), 15);
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 1);

    // Asynchronous reset mid-stream
    clr_d();
    bus.reg_write_d = 1'b1;
    bus.mem_write_d = 1'b1;
    bus.rd_d        = 5'd5;
    tick();
    tick();
    chk("mid_mem_write_m", 32'(bus.mem_write_m), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_mem_write_m_rst", 32'(bus.mem_write_m), 0);
    chk("mid_reg_write_e_rst", 32'(bus.reg_write_e), 0);
    chk("mid_rd_e_rst", 32'(bus.rd_e), 0);
    chk("mid_rd_w_rst", 32'(bus.rd_w), 0);
    chk("mid_flush_cnt_rst", 32'(bus.flush_cnt), 0);
    chk("mid_stall_cnt_rst", 32'(bus.stall_cnt), 0);
    chk("mid_fwd_a_rst", 32'(bus.forward_a_e), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_rd_e", 32'(bus.rd_e), 5);
    chk("post_rst_reg_write_e", 32'(bus.reg_write_e), 1);
    chk("post_rst_rd_m", 32'(bus.rd_m), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
